// File: rtl/pulse_sequencer.sv
// Pulse sequencer: issues start/stop calculation strobes for a programmed train of pulses.
// Latency: the start strobe follows an accepted START by one cycle; strobes, ERR and BUSY are registered.
// Backpressure: READY=0 at a period end stalls in WAIT_READY (sets OVERRUN); FLUSH holds until READY=1.
// Optional feature macro: CONTINUOUS_MODE_EN (NUM_PULSES=0 runs an endless train until ABORT).
module pulse_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CNT_WIDTH-1:0] PULSE_LEN,
  input  logic [CNT_WIDTH-1:0] PERIOD_LEN,
  input  logic [NUM_WIDTH-1:0] NUM_PULSES,
  input  logic                 READY,
  output logic                 SIGN_START_CALC,
  output logic                 SIGN_STOP_CALC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic                 OVERRUN,
  output logic [NUM_WIDTH-1:0] PULSE_IDX
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_READY, S_FLUSH} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [NUM_WIDTH-1:0] NUM_ONE = 1;

  state_t               r_state, w_state;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic [CNT_WIDTH-1:0] r_len, w_len;
  logic [CNT_WIDTH-1:0] r_per, w_per;
  logic [NUM_WIDTH-1:0] r_num, w_num;
  logic [NUM_WIDTH-1:0] r_idx, w_idx;
  logic                 r_ovr, w_ovr;
  // r_abrt marks the one cycle in which an abort-generated stop strobe is being emitted
  logic                 r_abrt, w_abrt;
  logic                 r_start, w_start;
  logic                 r_stop, w_stop;
  logic                 r_err, w_err;
  logic                 r_rej_done, w_rej_done;
  logic                 w_illegal;
  logic                 w_last;
  logic                 w_abort_stop;

  // Launch legality and last-pulse detection
  always_comb begin
`ifdef CONTINUOUS_MODE_EN
    w_illegal = (PULSE_LEN == '0) || (PERIOD_LEN <= PULSE_LEN);
    w_last    = (r_num != '0) && (r_idx == r_num - NUM_ONE);
`else
    w_illegal = (PULSE_LEN == '0) || (NUM_PULSES == '0) || (PERIOD_LEN <= PULSE_LEN);
    w_last    = (r_idx == r_num - NUM_ONE);
`endif
  end

  // Next-state, counter and strobe decode
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_len        = r_len;
    w_per        = r_per;
    w_num        = r_num;
    w_idx        = r_idx;
    w_ovr        = r_ovr;
    w_abrt       = 1'b0;
    w_err        = 1'b0;
    w_rej_done   = 1'b0;
    w_abort_stop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START && READY) begin
          if (w_illegal) begin
            w_err      = 1'b1;
            w_rej_done = 1'b1;
          end else begin
            w_len   = PULSE_LEN;
            w_per   = PERIOD_LEN;
            w_num   = NUM_PULSES;
            w_cnt   = '0;
            w_idx   = '0;
            w_ovr   = 1'b0;
            w_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_abrt) begin
          // abort stop strobe is out this cycle; drain next
          w_state = S_FLUSH;
        end else if (ABORT) begin
          if (r_cnt < r_len) begin
            w_abort_stop = 1'b1;
            w_abrt       = 1'b1;
            w_cnt        = r_cnt + CNT_ONE;
          end else begin
            w_state = S_FLUSH;
          end
        end else if (r_cnt == r_per - CNT_ONE) begin
          if (w_last) begin
            w_state = S_FLUSH;
          end else if (READY) begin
            w_cnt = '0;
            w_idx = r_idx + NUM_ONE;
          end else begin
            w_ovr   = 1'b1;
            w_state = S_WAIT_READY;
          end
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_READY: begin
        if (ABORT) begin
          w_state = S_FLUSH;
        end else if (READY) begin
          w_cnt   = '0;
          w_idx   = r_idx + NUM_ONE;
          w_state = S_RUN;
        end
      end
      S_FLUSH: begin
        if (READY) begin
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // strobes are registered: decode them from the state/count of the coming cycle
    w_start = (w_state == S_RUN) && (w_cnt == '0);
    w_stop  = w_abort_stop || ((w_state == S_RUN) && (w_cnt == w_len));
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_per      <= '0;
      r_num      <= '0;
      r_idx      <= '0;
      r_ovr      <= 1'b0;
      r_abrt     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_err      <= 1'b0;
      r_rej_done <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_per      <= w_per;
      r_num      <= w_num;
      r_idx      <= w_idx;
      r_ovr      <= w_ovr;
      r_abrt     <= w_abrt;
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_err      <= w_err;
      r_rej_done <= w_rej_done;
    end
  end

  assign SIGN_START_CALC = r_start;
  assign SIGN_STOP_CALC  = r_stop;
  assign BUSY            = (r_state != S_IDLE);
  // end of train is flagged in the FLUSH cycle that sees READY, or the cycle after a rejected launch
  assign DONE            = r_rej_done || ((r_state == S_FLUSH) && READY);
  assign ERR             = r_err;
  assign OVERRUN         = r_ovr;
  assign PULSE_IDX       = r_idx;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: cycle numbers are relative to the first cycle after launch.
module tb_pulse_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [15:0] PULSE_LEN = '0;
  logic [15:0] PERIOD_LEN = '0;
  logic [7:0]  NUM_PULSES = '0;
  logic        READY = 1'b1;
  logic        SIGN_START_CALC, SIGN_STOP_CALC, BUSY, DONE, ERR, OVERRUN;
  logic [7:0]  PULSE_IDX;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] start_map, stop_map, done_map, err_map, idx_seq;
  int          busy_cnt, both_cnt;

  pulse_sequencer #(.CNT_WIDTH(16), .NUM_WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .PULSE_LEN(PULSE_LEN), .PERIOD_LEN(PERIOD_LEN), .NUM_PULSES(NUM_PULSES),
    .READY(READY), .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OVERRUN(OVERRUN), .PULSE_IDX(PULSE_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] m(input int a, input int b = -1, input int c = -1, input int d = -1);
    logic [63:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    return r;
  endfunction

  // Called just after a rising edge: presents a launch for one cycle, then scrambles the parameters.
  task automatic launch(input logic [15:0] len, input logic [15:0] per, input logic [7:0] num, input logic rdy);
    PULSE_LEN  = len;
    PERIOD_LEN = per;
    NUM_PULSES = num;
    START      = 1'b1;
    READY      = rdy;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    START      = 1'b0;
    READY      = 1'b1;
    PULSE_LEN  = 16'd1;
    PERIOD_LEN = 16'd3;
    NUM_PULSES = 8'd1;
  endtask

  // Runs n cycles; READY low in [lo_a, lo_b], ABORT high in cycle ab; records outputs per cycle.
  task automatic run(input int n, input int lo_a, input int lo_b, input int ab);
    start_map = '0; stop_map = '0; done_map = '0; err_map = '0; idx_seq = '0;
    busy_cnt = 0; both_cnt = 0;
    for (int c = 0; c < n; c++) begin
      READY = !(c >= lo_a && c <= lo_b);
      ABORT = (c == ab);
      @(negedge CLK);
      if (SIGN_START_CALC) begin
        start_map[c] = 1'b1;
        idx_seq = {idx_seq[55:0], PULSE_IDX};
      end
      if (SIGN_STOP_CALC) stop_map[c] = 1'b1;
      if (DONE) done_map[c] = 1'b1;
      if (ERR) err_map[c] = 1'b1;
      if (BUSY) busy_cnt++;
      if (SIGN_START_CALC && SIGN_STOP_CALC) both_cnt++;
      @(posedge CLK);
      #1;
    end
    READY = 1'b1;
    ABORT = 1'b0;
  endtask

  task automatic check_nominal(input string p);
    chk({p, "_starts"}, start_map, m(0, 10, 20));
    chk({p, "_stops"}, stop_map, m(4, 14, 24));
    chk({p, "_done"}, done_map, m(30));
    chk({p, "_idx"}, idx_seq, 64'h000102);
    chk({p, "_busy"}, 64'(busy_cnt), 64'd31);
    chk({p, "_ovr"}, 64'(OVERRUN), 64'd0);
    chk({p, "_excl"}, 64'(both_cnt), 64'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs", 64'({SIGN_START_CALC, SIGN_STOP_CALC, BUSY, DONE, ERR, OVERRUN, PULSE_IDX}), 64'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // nominal train
    launch(16'd4, 16'd10, 8'd3, 1'b1);
    run(40, -1, -1, -1);
    check_nominal("s1");

    // READY low over cycles 9..13: overrun, second pulse delayed
    launch(16'd4, 16'd10, 8'd3, 1'b1);
    run(45, 9, 13, -1);
    chk("s2_starts", start_map, m(0, 15, 25));
    chk("s2_stops", stop_map, m(4, 19, 29));
    chk("s2_done", done_map, m(35));
    chk("s2_idx", idx_seq, 64'h000102);
    chk("s2_busy", 64'(busy_cnt), 64'd36);
    chk("s2_ovr", 64'(OVERRUN), 64'd1);

    // PERIOD_LEN == PULSE_LEN is rejected; OVERRUN survives a rejected launch
    launch(16'd6, 16'd6, 8'd3, 1'b1);
    run(5, -1, -1, -1);
    chk("s3_err", err_map, m(0));
    chk("s3_done", done_map, m(0));
    chk("s3_busy", 64'(busy_cnt), 64'd0);
    chk("s3_strobes", start_map | stop_map, 64'd0);
    chk("s3_ovr", 64'(OVERRUN), 64'd1);

    // START while READY=0 is ignored
    launch(16'd4, 16'd10, 8'd3, 1'b0);
    run(5, -1, -1, -1);
    chk("s3b_busy", 64'(busy_cnt), 64'd0);
    chk("s3b_any", start_map | err_map | done_map, 64'd0);

    // abort at cnt=3 of pulse 1
    launch(16'd8, 16'd20, 8'd5, 1'b1);
    run(40, -1, -1, 23);
    chk("s4_starts", start_map, m(0, 20));
    chk("s4_stops", stop_map, m(8, 24));
    chk("s4_done", done_map, m(25));
    chk("s4_busy", 64'(busy_cnt), 64'd26);
    chk("s4_ovr", 64'(OVERRUN), 64'd0);

    // reset at cnt=2 of pulse 0
    launch(16'd4, 16'd10, 8'd3, 1'b1);
    run(2, -1, -1, -1);
    RESET = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("s5_outs", 64'({SIGN_START_CALC, SIGN_STOP_CALC, BUSY, DONE, ERR, OVERRUN, PULSE_IDX}), 64'd0);
    @(posedge CLK);
    #1;
    run(10, -1, -1, -1);
    chk("s5_quiet", stop_map | start_map | done_map, 64'd0);
    chk("s5_busy", 64'(busy_cnt), 64'd0);
    launch(16'd4, 16'd10, 8'd3, 1'b1);
    run(40, -1, -1, -1);
    check_nominal("s5r");

    // NUM_PULSES=0
    launch(16'd2, 16'd4, 8'd0, 1'b1);
    run(20, -1, -1, 13);
`ifdef CONTINUOUS_MODE_EN
    chk("s6_starts", start_map, m(0, 4, 8, 12));
    chk("s6_stops", stop_map, m(2, 6, 10, 14));
    chk("s6_done", done_map, m(15));
    chk("s6_idx", idx_seq, 64'h00010203);
    chk("s6_busy", 64'(busy_cnt), 64'd16);
`else
    chk("s6_err", err_map, m(0));
    chk("s6_done", done_map, m(0));
    chk("s6_strobes", start_map | stop_map, 64'd0);
    chk("s6_busy", 64'(busy_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
